// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer (registered in_ready).
// Optional perf counters enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
  parameter int          SIDE_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h3000,
  parameter logic [31:0] EXC_PC   = 32'h4180,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  input  logic              in_bd,
  input  logic [4:0]        in_exc,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic              out_bd,
  output logic [4:0]        out_exc,
  output logic [SIDE_W-1:0] out_side,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int PAY_W = 32 + 1 + 5 + SIDE_W;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t             state_q, state_d;
  logic               in_ready_q, out_valid_q;
  logic [31:0]        fill_pc_q;
  logic [31:0]        head_pc_q, skid_pc_q;
  logic [PAY_W-1:0]   head_pay_q, skid_pay_q;
  logic [PAY_W-1:0]   in_pay;
  logic               in_fire, out_fire;
  logic               load_head_in, load_head_skid, load_skid, clear_head;

  assign in_pay   = {in_instr, in_bd, in_exc, in_side};
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    clear_head     = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d      = ONE;
          load_head_in = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && !out_fire) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (out_fire && !in_fire) begin
          state_d    = EMPTY;
          clear_head = 1'b1;
        end else if (in_fire && out_fire) begin
          load_head_in = 1'b1;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_d        = ONE;
          load_head_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Handshake flags are flops so neither output depends combinationally on the ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      fill_pc_q   <= RESET_PC;
    end else if (flush) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      fill_pc_q   <= EXC_PC;
    end else begin
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  // An empty head holds the fill PC and a zero payload, so out_* need no mux.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_pc_q  <= RESET_PC;
      head_pay_q <= '0;
      skid_pc_q  <= '0;
      skid_pay_q <= '0;
    end else if (flush) begin
      head_pc_q  <= EXC_PC;
      head_pay_q <= '0;
      skid_pc_q  <= '0;
      skid_pay_q <= '0;
    end else begin
      if (load_head_in) begin
        head_pc_q  <= in_pc;
        head_pay_q <= in_pay;
      end else if (load_head_skid) begin
        head_pc_q  <= skid_pc_q;
        head_pay_q <= skid_pay_q;
      end else if (clear_head) begin
        head_pc_q  <= fill_pc_q;
        head_pay_q <= '0;
      end
      if (load_skid) begin
        skid_pc_q  <= in_pc;
        skid_pay_q <= in_pay;
      end else if (load_head_skid) begin
        skid_pc_q  <= '0;
        skid_pay_q <= '0;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_pc    = head_pc_q;
  assign {out_instr, out_bd, out_exc, out_side} = head_pay_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q;

  // Saturating counters; flush deliberately leaves them alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (out_valid_q && !out_ready && stall_cnt_q != {CNT_W{1'b1}})
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (!out_valid_q && bubble_cnt_q != {CNT_W{1'b1}})
        bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule
